// File: rtl/axi_fifo_slice.sv
// axi_fifo_slice: AXI4 buffering slice with per-channel FIFOs and outstanding-transaction throttling
// Ports: s_* face the upstream master (AR/AW/W in, R/B out), m_* face the downstream slave
// (AR/AW/W out, R/B in); rd_outstanding/wr_outstanding count in-flight transactions and idle
// reports all FIFOs empty with both counters at zero.
module axi_fifo_slice_fifo #(
  parameter int W = 8,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         empty
);
  localparam int A = $clog2(D);
  logic [A:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [W-1:0] mem_q [D];
  logic full, push, pop;
  // The extra MSB is the wrap bit: equal indices with differing wrap bits means full.
  assign full      = (wptr_q[A] != rptr_q[A]) && (wptr_q[A-1:0] == rptr_q[A-1:0]);
  assign empty     = wptr_q == rptr_q;
  assign in_ready  = !full && !rst;
  assign out_valid = !empty;
  assign out_data  = mem_q[rptr_q[A-1:0]];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  always_comb begin
    wptr_d = push ? wptr_q + (A+1)'(1) : wptr_q;
    rptr_d = pop ? rptr_q + (A+1)'(1) : rptr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end
  always_ff @(posedge clk) if (push) mem_q[wptr_q[A-1:0]] <= in_data;
endmodule

module axi_fifo_slice #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 1,
  parameter int AR_DEPTH   = 2,
  parameter int AW_DEPTH   = 2,
  parameter int B_DEPTH    = 2,
  parameter int W_DEPTH    = 4,
  parameter int R_DEPTH    = 4,
  parameter int MAX_RD     = 8,
  parameter int MAX_WR     = 8,
  localparam int AXW = ID_WIDTH + ADDR_WIDTH + 30 + USER_WIDTH,
  localparam int WW  = DATA_WIDTH + DATA_WIDTH/8 + 1 + USER_WIDTH,
  localparam int RW  = ID_WIDTH + DATA_WIDTH + 3 + USER_WIDTH,
  localparam int BW  = ID_WIDTH + 2 + USER_WIDTH,
  localparam int RCW = $clog2(MAX_RD+1),
  localparam int WCW = $clog2(MAX_WR+1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           s_ar_valid,
  output logic           s_ar_ready,
  input  logic [AXW-1:0] s_ar_payload,
  input  logic           s_aw_valid,
  output logic           s_aw_ready,
  input  logic [AXW-1:0] s_aw_payload,
  input  logic           s_w_valid,
  output logic           s_w_ready,
  input  logic [WW-1:0]  s_w_payload,
  output logic           s_r_valid,
  input  logic           s_r_ready,
  output logic [RW-1:0]  s_r_payload,
  output logic           s_b_valid,
  input  logic           s_b_ready,
  output logic [BW-1:0]  s_b_payload,
  output logic           m_ar_valid,
  input  logic           m_ar_ready,
  output logic [AXW-1:0] m_ar_payload,
  output logic           m_aw_valid,
  input  logic           m_aw_ready,
  output logic [AXW-1:0] m_aw_payload,
  output logic           m_w_valid,
  input  logic           m_w_ready,
  output logic [WW-1:0]  m_w_payload,
  input  logic           m_r_valid,
  output logic           m_r_ready,
  input  logic [RW-1:0]  m_r_payload,
  input  logic           m_b_valid,
  output logic           m_b_ready,
  input  logic [BW-1:0]  m_b_payload,
  output logic [RCW-1:0] rd_outstanding,
  output logic [WCW-1:0] wr_outstanding,
  output logic           idle
);
  logic ar_ov, aw_ov, ar_e, aw_e, w_e, r_e, b_e;
  logic rd_full, wr_full, rd_inc, rd_dec, wr_inc, wr_dec;
  logic [RCW-1:0] rd_q, rd_d;
  logic [WCW-1:0] wr_q, wr_d;
  assign rd_full    = rd_q == RCW'(MAX_RD);
  assign wr_full    = wr_q == WCW'(MAX_WR);
  assign m_ar_valid = ar_ov && !rd_full;
  assign m_aw_valid = aw_ov && !wr_full;
  assign rd_inc     = m_ar_valid && m_ar_ready;
  // The last bit sits just above the user field in the R payload.
  assign rd_dec     = s_r_valid && s_r_ready && s_r_payload[USER_WIDTH];
  assign wr_inc     = m_aw_valid && m_aw_ready;
  assign wr_dec     = s_b_valid && s_b_ready;
  axi_fifo_slice_fifo #(.W(AXW), .D(AR_DEPTH)) u_ar (
    .clk(clk), .rst(rst), .in_valid(s_ar_valid), .in_ready(s_ar_ready), .in_data(s_ar_payload),
    .out_valid(ar_ov), .out_ready(m_ar_ready && !rd_full), .out_data(m_ar_payload), .empty(ar_e));
  axi_fifo_slice_fifo #(.W(AXW), .D(AW_DEPTH)) u_aw (
    .clk(clk), .rst(rst), .in_valid(s_aw_valid), .in_ready(s_aw_ready), .in_data(s_aw_payload),
    .out_valid(aw_ov), .out_ready(m_aw_ready && !wr_full), .out_data(m_aw_payload), .empty(aw_e));
  axi_fifo_slice_fifo #(.W(WW), .D(W_DEPTH)) u_w (
    .clk(clk), .rst(rst), .in_valid(s_w_valid), .in_ready(s_w_ready), .in_data(s_w_payload),
    .out_valid(m_w_valid), .out_ready(m_w_ready), .out_data(m_w_payload), .empty(w_e));
  axi_fifo_slice_fifo #(.W(RW), .D(R_DEPTH)) u_r (
    .clk(clk), .rst(rst), .in_valid(m_r_valid), .in_ready(m_r_ready), .in_data(m_r_payload),
    .out_valid(s_r_valid), .out_ready(s_r_ready), .out_data(s_r_payload), .empty(r_e));
  axi_fifo_slice_fifo #(.W(BW), .D(B_DEPTH)) u_b (
    .clk(clk), .rst(rst), .in_valid(m_b_valid), .in_ready(m_b_ready), .in_data(m_b_payload),
    .out_valid(s_b_valid), .out_ready(s_b_ready), .out_data(s_b_payload), .empty(b_e));
  // A completion with nothing outstanding is ignored rather than wrapping the counter.
  always_comb begin
    rd_d = (rd_inc && !rd_dec) ? rd_q + RCW'(1) : (rd_dec && !rd_inc && rd_q != '0) ? rd_q - RCW'(1) : rd_q;
    wr_d = (wr_inc && !wr_dec) ? wr_q + WCW'(1) : (wr_dec && !wr_inc && wr_q != '0) ? wr_q - WCW'(1) : wr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
    end
  end
  assign rd_outstanding = rd_q;
  assign wr_outstanding = wr_q;
  assign idle = ar_e && aw_e && w_e && r_e && b_e && rd_q == '0 && wr_q == '0;
  a_rd_underflow: assert property (@(posedge clk) disable iff (rst) !(rd_dec && !rd_inc && rd_q == '0));
  a_wr_underflow: assert property (@(posedge clk) disable iff (rst) !(wr_dec && !wr_inc && wr_q == '0));
endmodule

// File: doc/axi_fifo_slice.md
# axi_fifo_slice

Parametrised AXI4 buffering slice that sits between an AXI master (core/cache side) and the interconnect or memory side. All five channels get independent FIFOs of configurable depth. ID, address, data and user widths are configurable. Per-direction outstanding-transaction counters throttle address issue and report an idle status. Slave-side ports face the upstream master; master-side ports face the downstream slave.

## Interface
Parameters:
- ID_WIDTH, 4, AXI ID width
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 64, data width; power of two, >= 8
- USER_WIDTH, 1, user width on every channel
- AR_DEPTH / AW_DEPTH / B_DEPTH, 2, FIFO depths; power of two, >= 2
- W_DEPTH / R_DEPTH, 4, FIFO depths; power of two, >= 2
- MAX_RD / MAX_WR, 8, outstanding-transaction limits; >= 1

Derived payload widths (MSB first, struct field order, valid excluded):
- AX = ID+ADDR+8 len+3 size+2 burst+2 lock+4 cache+3 prot+4 qos+4 region+USER
- W = DATA + DATA/8 strb + 1 last + USER
- R = ID + DATA + 2 resp + 1 last + USER
- B = ID + 2 resp + USER

Ports:
- clk  in  1  single clock; everything is rising-edge
- rst  in  1  synchronous reset, active-high
- s_ar_valid / s_ar_ready / s_ar_payload  in/out/in  1/1/AX  upstream AR
- s_aw_valid / s_aw_ready / s_aw_payload  in/out/in  1/1/AX  upstream AW
- s_w_valid / s_w_ready / s_w_payload  in/out/in  1/1/W  upstream W
- s_r_valid / s_r_ready / s_r_payload  out/in/out  1/1/R  upstream R
- s_b_valid / s_b_ready / s_b_payload  out/in/out  1/1/B  upstream B
- m_ar_*, m_aw_*, m_w_*  directions mirrored, widths as above; downstream request side
- m_r_*, m_b_*  directions mirrored; downstream response side
- rd_outstanding  out  $clog2(MAX_RD+1)  reads issued downstream, not yet completed upstream
- wr_outstanding  out  $clog2(MAX_WR+1)  writes issued downstream, not yet completed upstream
- idle  out  1  all FIFOs empty and both counters zero

## Operation
Channel FIFOs:
- Each channel is a circular FIFO with registered read/write pointers plus a wrap bit.
- Input ready = !full; output valid = !empty. Neither depends combinationally on the opposite side's handshake.
- The payload is opaque; it is stored and forwarded bit-exact.
- Push and pop in the same cycle on a non-full, non-empty FIFO leave occupancy unchanged.
- When full, the input is refused for that cycle even if a pop occurs the same cycle.
- Pop of the last entry with a simultaneous push: output valid stays 1 the next cycle.
- Pointers wrap from DEPTH-1 to 0 and toggle the wrap bit. Full = pointers equal, wrap bits differ.

Read outstanding counter:
- Increments on an m_ar handshake.
- Decrements on an s_r handshake with the last bit set.
- Both in the same cycle: unchanged.
- While rd_outstanding == MAX_RD, m_ar_valid is forced to 0 (the AR FIFO still accepts until full).

Write outstanding counter:
- Increments on an m_aw handshake.
- Decrements on an s_b handshake.
- While wr_outstanding == MAX_WR, m_aw_valid is forced to 0.
- W data is never throttled; it may precede its AW.

Counter rules:
- Neither counter may underflow. A decrement at 0 is a protocol error: ignored, and flagged by a simulation assertion.

## Timing
- Reset (rst high at a clk edge): all FIFOs empty, both counters 0. All *_valid outputs are 0 and idle is 1 from the following cycle.
- All s_*_ready and m_*_ready outputs are forced to 0 while rst is high; they are 1 in the first cycle after rst deasserts.
- Reset mid-burst discards all buffered beats and counts. No beat is replayed.
- Latency: a beat pushed in cycle N is visible at the output in cycle N+1.
- Throughput: one beat per cycle per channel in steady state.
- The outstanding limit takes effect the cycle after the counter reaches MAX. Release takes effect the cycle after the completing R-last or B handshake.
- idle is registered from the state after each edge.

## Test plan
- Reset: hold rst 3 cycles with s_ar_valid=1 -> all readies 0 during reset, no m_ar_valid. After release, s_*_ready=1, idle=1, counters 0.
- Streaming: 16 back-to-back W beats, m_w_ready=1 -> each beat appears 1 cycle later, 16 consecutive cycles, payload bit-exact.
- Full/backpressure: W_DEPTH=4, m_w_ready=0, push 6 beats -> s_w_ready drops after the 4th beat. Releasing m_w_ready drains 4 beats in order.
- Read throttle: MAX_RD=2, issue 3 ARs with no R returned -> rd_outstanding=2, third AR held. Return R (len 0, last=1) -> third AR issued next cycle, count returns to 2.
- Simultaneous inc/dec: m_aw handshake and s_b handshake in the same cycle with wr_outstanding=1 -> count stays 1.
- Pointer wrap: 3*DEPTH+1 pushes/pops with random ready stalls on every channel -> order preserved, no loss or duplication, idle=1 at the end.
